// File: rtl/fir_capture_pkg.sv
// Shared types and default geometry for the FIR output capture buffer.
// Optional peak tracking in the top level is enabled by CAPTURE_PEAK_EN.
package fir_capture_pkg;

    localparam int unsigned N_DEF      = 16;
    localparam int unsigned DEPTH_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/fir_capture_ram.sv
// DEPTH x N sample store: one write port, one synchronous read port.
// The read register resets to zero and holds its value when no read is issued.
module fir_capture_ram #(
    parameter int unsigned N      = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [N-1:0]      rdata
);

    logic [N-1:0] mem [DEPTH];

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_sample_capture.sv
// Captures FIR_Filter output into a circular/one-shot sample buffer with readback.
// Define CAPTURE_PEAK_EN to build signed peak_max/peak_min tracking; otherwise they read 0.
module fir_sample_capture
    import fir_capture_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic              continuous,
    input  logic              in_valid,
    input  logic [N-1:0]      data_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic [N-1:0]      peak_max,
    output logic [N-1:0]      peak_min
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = FULL - 1'b1;

    cap_state_t state;
    logic       mode;
    logic       wr_fire;
    logic       rd_fire;

    // abort outranks every other request; start in DONE outranks a read.
    assign wr_fire = (state == CAPTURE) && in_valid && !abort;
    assign rd_fire = (state == DONE) && rd_en && !start && !abort;

    assign busy = (state == CAPTURE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mode     <= 1'b0;
            wr_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state   <= CAPTURE;
                            mode    <= continuous;
                            wr_ptr  <= '0;
                            count   <= '0;
                            wrapped <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (in_valid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (count != FULL) begin
                                count <= count + 1'b1;
                            end
                            if (wr_ptr == '1) begin
                                wrapped <= 1'b1;
                            end
                        end
                        // A stop coinciding with a sample still lets that sample land.
                        if (stop || (in_valid && !mode && count == LAST)) begin
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CAPTURE_PEAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_max <= '0;
            peak_min <= '0;
        end else if (wr_fire) begin
            if (count == '0) begin
                peak_max <= data_in;
                peak_min <= data_in;
            end else begin
                if ($signed(data_in) > $signed(peak_max)) begin
                    peak_max <= data_in;
                end
                if ($signed(data_in) < $signed(peak_min)) begin
                    peak_min <= data_in;
                end
            end
        end
    end
`else
    assign peak_max = '0;
    assign peak_min = '0;
`endif

    fir_capture_ram #(
        .N      (N),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_fire),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fir_sample_capture.sv
// Self-checking bench for fir_sample_capture: directed scenarios plus random traffic
// against a sample-count based reference model; honours CAPTURE_PEAK_EN.
module tb_fir_sample_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        wrapped;
    logic [4:0]  wr_ptr;
    logic [5:0]  count;
    logic [15:0] peak_max;
    logic [15:0] peak_min;

    always #5 clk = ~clk;

    fir_sample_capture #(
        .N      (16),
        .DEPTH  (32),
        .ADDR_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .continuous (continuous),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .wr_ptr     (wr_ptr),
        .count      (count),
        .peak_max   (peak_max),
        .peak_min   (peak_min)
    );

    // Model: phase 0 = idle, 1 = capturing, 2 = done; m_n = samples written since start.
    int                 n_checks = 0;
    int                 n_fail = 0;
    int                 m_phase;
    int                 m_n;
    bit                 m_mode;
    logic [15:0]        m_mem [32];
    bit                 m_known [32];
    logic [15:0]        m_rdata;
    bit                 m_rd_known;
    bit                 m_rvalid;
    logic signed [15:0] m_pmax;
    logic signed [15:0] m_pmin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_n        = 0;
        m_mode     = 1'b0;
        m_rdata    = '0;
        m_rd_known = 1'b1;
        m_rvalid   = 1'b0;
        m_pmax     = '0;
        m_pmin     = '0;
        for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    endtask

    task automatic model_step();
        m_rvalid = 1'b0;
        if (abort) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_mem[m_n % 32]   = data_in;
                m_known[m_n % 32] = 1'b1;
`ifdef CAPTURE_PEAK_EN
                if (m_n == 0) begin
                    m_pmax = data_in;
                    m_pmin = data_in;
                end else begin
                    if ($signed(data_in) > m_pmax) m_pmax = data_in;
                    if ($signed(data_in) < m_pmin) m_pmin = data_in;
                end
`endif
                m_n++;
                if (!m_mode && m_n == 32) m_phase = 2;
            end
            if (stop) m_phase = 2;
        end else if (start) begin
            m_phase = 1;
            m_n     = 0;
            m_mode  = continuous;
        end else if (m_phase == 2 && rd_en) begin
            m_rvalid   = 1'b1;
            m_rdata    = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
        end
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_phase == 1));
        check("done", 32'(done), 32'(m_phase == 2));
        check("wrapped", 32'(wrapped), 32'(m_n >= 32));
        check("wr_ptr", 32'(wr_ptr), 32'(m_n % 32));
        check("count", 32'(count), 32'((m_n > 32) ? 32 : m_n));
        check("rd_valid", 32'(rd_valid), 32'(m_rvalid));
        if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rdata));
        check("peak_max", 32'(peak_max), 32'(m_pmax));
        check("peak_min", 32'(peak_min), 32'(m_pmin));
    endtask

    // One clock: model advances on the edge, DUT compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        start    = 1'b0;
        stop     = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic do_start(input logic cont);
        clear_inputs();
        continuous = cont;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        data_in  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read(input logic [4:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        check("lit_reset_count", 32'(count), 32'd0);
        check("lit_reset_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        tick();

        // One-shot, 0..31 back to back
        do_start(1'b0);
        for (int i = 0; i < 32; i++) push(16'(i));
        check("lit_oneshot_done", 32'(done), 32'd1);
        check("lit_oneshot_count", 32'(count), 32'd32);
        check("lit_oneshot_wrapped", 32'(wrapped), 32'd1);
        check("lit_oneshot_wr_ptr", 32'(wr_ptr), 32'd0);
        push(16'h0063);
        read(5'd5);
        check("lit_oneshot_rd5", 32'(rd_data), 32'd5);
        check("lit_oneshot_rv", 32'(rd_valid), 32'd1);
        tick();

        // Gapped input
        do_start(1'b0);
        for (int c = 0; c < 64; c++) begin
            in_valid = (c % 2 == 0);
            data_in  = 16'(1000 + c);
            tick();
        end
        in_valid = 1'b0;
        check("lit_gap_done", 32'(done), 32'd1);
        for (int a = 0; a < 32; a++) read(5'(a));
        read(5'd31);
        check("lit_gap_rd31", 32'(rd_data), 32'd1062);

        // Continuous, 40 samples then stop
        do_start(1'b1);
        for (int i = 0; i < 40; i++) push(16'(100 + i));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("lit_cont_wr_ptr", 32'(wr_ptr), 32'd8);
        check("lit_cont_count", 32'(count), 32'd32);
        check("lit_cont_wrapped", 32'(wrapped), 32'd1);
        read(5'd8);
        check("lit_cont_rd8", 32'(rd_data), 32'd108);
        read(5'd7);
        check("lit_cont_rd7", 32'(rd_data), 32'd139);

        // Priorities
        do_start(1'b0);
        for (int i = 0; i < 9; i++) push(16'(500 + i));
        stop = 1'b1;
        push(16'd509);
        stop = 1'b0;
        check("lit_stop10_count", 32'(count), 32'd10);
        check("lit_stop10_done", 32'(done), 32'd1);
        rd_en = 1'b1;
        start = 1'b1;
        rd_addr = 5'd3;
        tick();
        clear_inputs();
        check("lit_start_beats_rd", 32'(rd_valid), 32'd0);
        read(5'd2);
        check("lit_cap_rd_valid", 32'(rd_valid), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        clear_inputs();
        check("lit_abort_busy", 32'(busy), 32'd0);
        check("lit_abort_done", 32'(done), 32'd0);

        // Async reset mid-capture
        do_start(1'b0);
        for (int i = 0; i < 5; i++) push(16'(700 + i));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("lit_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        do_start(1'b0);
        for (int i = 0; i < 32; i++) push(16'(2000 + i));
        read(5'd17);
        check("lit_after_rst_rd17", 32'(rd_data), 32'd2017);

        // Peak tracking
        do_start(1'b0);
        push(16'sd300);
        push(-16'sd1200);
        push(16'sd32767);
        push(-16'sd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`ifdef CAPTURE_PEAK_EN
        check("lit_peak_max", 32'(peak_max), 32'h7FFF);
        check("lit_peak_min", 32'(peak_min), 32'hFB50);
`else
        check("lit_peak_max", 32'(peak_max), 32'h0);
        check("lit_peak_min", 32'(peak_min), 32'h0);
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            abort      = ($urandom_range(0, 59) == 0);
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            continuous = 1'($urandom_range(0, 1));
            in_valid   = ($urandom_range(0, 9) < 7);
            data_in    = 16'($urandom());
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = 5'($urandom_range(0, 31));
            tick();
        end
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_capture.md
# fir_sample_capture

Captures the filtered output stream of `FIR_Filter` into a 32-entry sample buffer for later readback, the receive-side counterpart of the stimulus RAM that plays sine samples into the filter. It sits on the filter's `data_out` and accepts samples qualified by `in_valid`. It supports one-shot capture of exactly DEPTH samples, or continuous circular capture terminated by `stop`. Captured samples are read back through a synchronous read port once capture is complete.

## Interface
- `N`, 16, sample width (signed two's complement).
- `DEPTH`, 32, buffer entries; power of two.
- `ADDR_W`, 5, log2(DEPTH).

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: arm and begin capture (pulse).
- `stop` in 1: end continuous capture (pulse).
- `abort` in 1: return to IDLE from any state.
- `continuous` in 1: 1 = circular capture, 0 = one-shot; sampled at `start`.
- `in_valid` in 1: `data_in` holds a sample this cycle.
- `data_in` in N: filter output sample.
- `rd_en` in 1: read request.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out N: read data.
- `rd_valid` out 1: `rd_data` valid.
- `busy` out 1: state is CAPTURE.
- `done` out 1: state is DONE.
- `wrapped` out 1: buffer has been fully written at least once since `start`.
- `wr_ptr` out ADDR_W: next write address, which is the oldest entry once `wrapped` = 1.
- `count` out ADDR_W+1: samples written since `start`, saturating at DEPTH.
- `peak_max` out N: signed maximum of the samples captured since `start`.
- `peak_min` out N: signed minimum of the samples captured since `start`.

## Operation
- States and transitions:
  - IDLE → CAPTURE on `start`.
  - DONE → CAPTURE on `start`.
  - CAPTURE → DONE after the DEPTH-th write (one-shot), or on `stop` (either mode).
  - Any state → IDLE on `abort`.
- On entering CAPTURE:
  - `wr_ptr` and `count` clear to 0, `wrapped` clears to 0.
  - The mode latches from `continuous`.
- In CAPTURE, each cycle with `in_valid` = 1:
  - Writes `data_in` to mem[`wr_ptr`].
  - Increments `wr_ptr` modulo DEPTH (31 → 0).
  - Increments `count`, saturating at DEPTH.
  - `wrapped` sets when `wr_ptr` wraps 31 → 0.
- One-shot: the write that makes `count` = DEPTH also moves the block to DONE. Any further `in_valid` is dropped.
- Continuous: writes keep overwriting the oldest entries until `stop`.
- `in_valid` outside CAPTURE is ignored. The buffer is not written.
- Reads are honored only in DONE. A `rd_en` in any other state gives `rd_valid` = 0 on the next cycle.
- Priorities:
  - `abort` beats everything else.
  - `start` is ignored while in CAPTURE.
  - `stop` in the same cycle as `in_valid`: the sample is written, then the block enters DONE.
  - `start` in DONE together with `rd_en`: `start` wins and the read is not honored.
- An `abort` mid-capture preserves buffer contents and leaves `count`/`wr_ptr` frozen.
- An asynchronous reset mid-capture leaves memory contents undefined and takes the block to IDLE.
- Reset values:
  - State IDLE.
  - `busy` = `done` = `wrapped` = 0.
  - `wr_ptr` = 0, `count` = 0.
  - `rd_data` = 0, `rd_valid` = 0.
  - `peak_max` = `peak_min` = 0.

## Timing
- Writes and counter updates take effect at the posedge where `in_valid` is sampled.
- `done` rises on the same edge that performs the DEPTH-th write, or the edge that samples `stop`.
- `busy` rises on the edge that samples `start`.
- Read latency is 1 cycle: `rd_en` at edge k gives `rd_data`/`rd_valid` after edge k. Otherwise `rd_valid` is 0 and `rd_data` holds its last value.
- Full bandwidth: one sample per cycle, no backpressure.

## Configuration
- `CAPTURE_PEAK_EN` defined:
  - `peak_max`/`peak_min` are loaded with the first captured sample after `start`.
  - After that they update with a signed compare on each write.
  - They hold their values in DONE and IDLE.
- `CAPTURE_PEAK_EN` undefined: ports remain and are tied to 0, and no compare logic is built.

## Structure
- Package `fir_capture_pkg`:
  - State enum {IDLE, CAPTURE, DONE}.
  - Default `N`/`DEPTH`/`ADDR_W` constants.
- Sub-module `fir_capture_ram`: DEPTH×N storage with one write port and one synchronous read port (registered output).
- Top level holds the FSM, pointers, flags and peak logic.

## Test plan
- One-shot: `start`, then 32 consecutive `in_valid` samples 0..31 → `done` = 1 after the 32nd edge, `count` = 32, `wrapped` = 1, `wr_ptr` = 0; reading addr 5 → `rd_data` = 5 one cycle later.
- Gapped input: `in_valid` toggling every other cycle for 64 cycles → exactly 32 writes, `done` after the last one, no sample lost or duplicated.
- Continuous: `continuous` = 1, 40 samples 100..139, then `stop` → `wrapped` = 1, `wr_ptr` = 8, `count` = 32; addr 8 reads 108, addr 7 reads 139.
- Priority: `stop` together with the 10th `in_valid` → 10 written, DONE; `abort` together with `start` → IDLE; `rd_en` in CAPTURE → `rd_valid` = 0.
- Reset: `reset` low mid-capture → all outputs at reset values immediately; the next `start` captures normally.
- Peak (with `CAPTURE_PEAK_EN`): samples +300, −1200, +32767, −5 → `peak_max` = 32767, `peak_min` = −1200; without the macro both read 0.
